std_divmod_pipe: RTL and testbench



---
 rtl/std_divmod_pkg.sv | 15 +
 rtl/std_udiv_step.sv | 21 ++
 rtl/std_divmod_pipe.sv | 150 +++++++++++++++
 tb/tb_std_divmod_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/std_divmod_pkg.sv
// Shared types and helpers for the iterative unsigned divide/modulo unit.
package std_divmod_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } divmod_state_e;

  // Width of a counter that can hold width/step (the RUN iteration count).
  function automatic int unsigned divmod_cnt_width(input int unsigned w, input int unsigned step);
    return $clog2(w / step + 1);
  endfunction

endpackage

// File: rtl/std_udiv_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module std_udiv_step #(
  parameter int unsigned width = 32
) (
  input  logic [width-1:0] rem_in,
  input  logic [width-1:0] divisor,
  input  logic             dividend_bit,
  output logic [width-1:0] rem_out,
  output logic             quotient_bit
);

  logic [width:0] shifted;

  always_comb begin
    shifted      = {rem_in, dividend_bit};
    quotient_bit = (shifted >= {1'b0, divisor});
    // The difference is below the divisor, so the low width bits are exact.
    rem_out      = quotient_bit ? (shifted[width-1:0] - divisor) : shifted[width-1:0];
  end

endmodule

// File: rtl/std_divmod_pipe.sv
// Iterative unsigned divider returning quotient and remainder, STEP quotient bits per cycle,
// with go/done handshake, defined divide-by-zero result and abort on go deassertion.
module std_divmod_pipe
  import std_divmod_pkg::*;
#(
  parameter int unsigned width = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
  output logic             div_by_zero,
  output logic             done
);

  localparam int unsigned Iters = width / STEP;
  localparam int unsigned CntW  = divmod_cnt_width(width, STEP);

  if (STEP == 0 || (width % STEP) != 0) begin : g_bad_step
    $error("std_divmod_pipe: STEP must be nonzero and divide width exactly");
  end

  divmod_state_e   state_q, state_d;
  logic [width-1:0] divisor_q, divisor_d;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [width-1:0] acc_q, acc_d;
  logic [width-1:0] rem_q, rem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [width-1:0] quo_out_q, quo_out_d;
  logic [width-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic [STEP-1:0]  q_bits;
  logic [width-1:0] rem_last;
  logic [width-1:0] acc_shift;

  for (genvar i = 0; i < STEP; i++) begin : g_step
    logic [width-1:0] rem_in;
    logic [width-1:0] rem_o;
    if (i == 0) begin : g_first
      assign rem_in = rem_q;
    end else begin : g_next
      assign rem_in = g_step[i-1].rem_o;
    end
    std_udiv_step #(
      .width(width)
    ) u_step (
      .rem_in       (rem_in),
      .divisor      (divisor_q),
      .dividend_bit (acc_q[width-1-i]),
      .rem_out      (rem_o),
      .quotient_bit (q_bits[STEP-1-i])
    );
  end

  assign rem_last = g_step[STEP-1].rem_o;

  if (STEP == width) begin : g_acc_full
    assign acc_shift = q_bits;
  end else begin : g_acc_part
    assign acc_shift = {acc_q[width-1-STEP:0], q_bits};
  end

  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          divisor_d = right;
          acc_d     = left;
          rem_d     = '0;
          cnt_d     = CntW'(Iters);
          if (right == '0) begin
            quo_out_d = '1;
            rem_out_d = left;
            dbz_d     = 1'b1;
            state_d   = StDone;
          end else if (left == '0) begin
            quo_out_d = '0;
            rem_out_d = '0;
            dbz_d     = 1'b0;
            state_d   = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!go) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_shift;
          rem_d = rem_last;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            quo_out_d = acc_shift;
            rem_out_d = rem_last;
            dbz_d     = 1'b0;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      divisor_q <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end

  assign out_quotient  = quo_out_q;
  assign out_remainder = rem_out_q;
  assign div_by_zero   = dbz_q;
  assign done          = (state_q == StDone) && !reset;

endmodule

// File: tb/tb_std_divmod_pipe.sv
// Bench for std_divmod_pipe: width-8 vector table, abort/reset sequences, width-16 random sweep.
module tb_std_divmod_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Width 8 instances: STEP = 1,2,4,8. Width 16 instances: STEP = 1,2,4,8,16.
  logic        go8 [4];
  logic [7:0]  l8  [4];
  logic [7:0]  r8  [4];
  logic [7:0]  q8  [4];
  logic [7:0]  m8  [4];
  logic        z8  [4];
  logic        d8  [4];

  logic        go16 [5];
  logic [15:0] l16  [5];
  logic [15:0] r16  [5];
  logic [15:0] q16  [5];
  logic [15:0] m16  [5];
  logic        z16  [5];
  logic        d16  [5];

  for (genvar k = 0; k < 4; k++) begin : g_w8
    std_divmod_pipe #(
      .width(8),
      .STEP (1 << k)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .go           (go8[k]),
      .left         (l8[k]),
      .right        (r8[k]),
      .out_quotient (q8[k]),
      .out_remainder(m8[k]),
      .div_by_zero  (z8[k]),
      .done         (d8[k])
    );
  end

  for (genvar k = 0; k < 5; k++) begin : g_w16
    std_divmod_pipe #(
      .width(16),
      .STEP (1 << k)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .go           (go16[k]),
      .left         (l16[k]),
      .right        (r16[k]),
      .out_quotient (q16[k]),
      .out_remainder(m16[k]),
      .div_by_zero  (z16[k]),
      .done         (d16[k])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int w, input int k, input logic g, input logic [15:0] l,
                        input logic [15:0] r);
    if (w == 8) begin
      go8[k] = g;
      l8[k]  = l[7:0];
      r8[k]  = r[7:0];
    end else begin
      go16[k] = g;
      l16[k]  = l;
      r16[k]  = r;
    end
  endtask

  function automatic logic get_done(input int w, input int k);
    return (w == 8) ? d8[k] : d16[k];
  endfunction
  function automatic logic [15:0] get_q(input int w, input int k);
    return (w == 8) ? {8'd0, q8[k]} : q16[k];
  endfunction
  function automatic logic [15:0] get_m(input int w, input int k);
    return (w == 8) ? {8'd0, m8[k]} : m16[k];
  endfunction
  function automatic logic get_z(input int w, input int k);
    return (w == 8) ? z8[k] : z16[k];
  endfunction

  // Start an operation, wait (bounded) for done, check latency/results and single-cycle done.
  task automatic run_op(input int w, input int k, input logic [15:0] l, input logic [15:0] r,
                        input logic [15:0] eq, input logic [15:0] em, input logic ez,
                        input int elat, input bit perturb, input string name);
    int n = 0;
    bit seen = 0;
    set_in(w, k, 1'b1, l, r);
    while (!seen && n < 64) begin
      @(posedge clk);
      #1;
      n++;
      if (perturb) set_in(w, k, 1'b1, 16'($urandom), 16'($urandom));
      if (get_done(w, k)) seen = 1;
    end
    if (!seen) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_lat"}, n, elat);
      check({name, "_q"}, get_q(w, k), eq);
      check({name, "_r"}, get_m(w, k), em);
      check({name, "_z"}, get_z(w, k), ez);
    end
    set_in(w, k, 1'b0, l, r);
    @(posedge clk);
    #1;
    check({name, "_pulse"}, get_done(w, k), 1'b0);
  endtask

  typedef struct {
    int         k;
    logic [7:0] l;
    logic [7:0] r;
    logic [7:0] q;
    logic [7:0] m;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    logic [15:0] a, b, eq, em;
    logic ez;
    int k, elat;

    vecs[0]  = '{0, 8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 9};
    vecs[1]  = '{1, 8'd255, 8'd16,  8'd15,  8'd15, 1'b0, 5};
    vecs[2]  = '{2, 8'd255, 8'd16,  8'd15,  8'd15, 1'b0, 3};
    vecs[3]  = '{0, 8'd42,  8'd0,   8'd255, 8'd42, 1'b1, 1};
    vecs[4]  = '{0, 8'd10,  8'd3,   8'd3,   8'd1,  1'b0, 9};
    vecs[5]  = '{3, 8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 2};
    vecs[6]  = '{0, 8'd5,   8'd200, 8'd0,   8'd5,  1'b0, 9};
    vecs[7]  = '{1, 8'd0,   8'd9,   8'd0,   8'd0,  1'b0, 1};
    vecs[8]  = '{2, 8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 3};
    vecs[9]  = '{3, 8'd0,   8'd0,   8'd255, 8'd0,  1'b1, 1};
    vecs[10] = '{1, 8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 5};

    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_in(8, i, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 5; i++) set_in(16, i, 1'b0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst8_%0d_q", i), get_q(8, i), 16'd0);
      check($sformatf("rst8_%0d_done", i), get_done(8, i), 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst16_%0d_r", i), get_m(16, i), 16'd0);
      check($sformatf("rst16_%0d_z", i), get_z(16, i), 1'b0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      run_op(8, vecs[i].k, {8'd0, vecs[i].l}, {8'd0, vecs[i].r}, {8'd0, vecs[i].q},
             {8'd0, vecs[i].m}, vecs[i].z, vecs[i].lat, 1'b0, $sformatf("vec%0d", i));
    end

    // Abort: 100/3 on STEP=1, go dropped after cycle 4; previous 10/3 results must survive.
    run_op(8, 0, 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 9, 1'b0, "pre_abort");
    saw = 0;
    set_in(8, 0, 1'b1, 16'd100, 16'd3);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      if (get_done(8, 0)) saw = 1;
    end
    set_in(8, 0, 1'b0, 16'd100, 16'd3);
    repeat (12) begin
      @(posedge clk);
      #1;
      if (get_done(8, 0)) saw = 1;
    end
    check("abort_no_done", saw, 1'b0);
    check("abort_q", get_q(8, 0), 16'd3);
    check("abort_r", get_m(8, 0), 16'd1);
    check("abort_z", get_z(8, 0), 1'b0);
    run_op(8, 0, 16'd100, 16'd3, 16'd33, 16'd1, 1'b0, 9, 1'b0, "post_abort");

    // Reset mid-operation at cycle 3.
    saw = 0;
    set_in(8, 0, 1'b1, 16'd100, 16'd3);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (get_done(8, 0)) saw = 1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_q", get_q(8, 0), 16'd0);
    check("midrst_r", get_m(8, 0), 16'd0);
    check("midrst_done", get_done(8, 0), 1'b0);
    reset = 1'b0;
    set_in(8, 0, 1'b0, 16'd100, 16'd3);
    repeat (12) begin
      @(posedge clk);
      #1;
      if (get_done(8, 0)) saw = 1;
    end
    check("midrst_no_done", saw, 1'b0);
    run_op(8, 0, 16'd100, 16'd3, 16'd33, 16'd1, 1'b0, 9, 1'b0, "post_rst");

    // Random sweep at width 16 against plain / and %, operands scrambled while running.
    for (int i = 0; i < 2500; i++) begin
      k = i % 5;
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 6))
        0: a = 16'd0;
        1: b = 16'd1;
        2: begin
          a = 16'($urandom_range(0, 255));
          b = 16'($urandom_range(256, 65535));
        end
        3: a = 16'hFFFF;
        4: b = 16'hFFFF;
        5: b = 16'd0;
        default: ;
      endcase
      if (b == 0) begin
        eq = 16'hFFFF;
        em = a;
        ez = 1'b1;
      end else begin
        eq = a / b;
        em = a % b;
        ez = 1'b0;
      end
      elat = (a == 0 || b == 0) ? 1 : 16 / (1 << k) + 1;
      run_op(16, k, a, b, eq, em, ez, elat, 1'b1, $sformatf("rnd%0d_s%0d", i, 1 << k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
